// File: rtl/key_entry_pkg.sv
// Shared types and helpers for the keypad entry / display mux block.
// Optional feature macro: ZERO_BLANK_EN (see key_entry_ctrl.sv).
package key_entry_pkg;

    typedef enum logic [1:0] {SHOW_L, BLANK_LR, SHOW_R, BLANK_RL} sched_state_t;

    localparam int DEF_MUX_DIV      = 24_000;
    localparam int DEF_BLANK_CYCLES = 48;

    // True when exactly one bit of the nibble is set.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Bit index of a one-hot nibble (result is meaningless otherwise).
    function automatic logic [1:0] idx4(input logic [3:0] v);
        return {v[3] | v[2], v[3] | v[1]};
    endfunction

    // Keypad legend: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
    function automatic logic [3:0] key_hex(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] h;
        case ({row, col})
            4'h0: h = 4'h1;  4'h1: h = 4'h2;  4'h2: h = 4'h3;  4'h3: h = 4'hA;
            4'h4: h = 4'h4;  4'h5: h = 4'h5;  4'h6: h = 4'h6;  4'h7: h = 4'hB;
            4'h8: h = 4'h7;  4'h9: h = 4'h8;  4'hA: h = 4'h9;  4'hB: h = 4'hC;
            4'hC: h = 4'hE;  4'hD: h = 4'h0;  4'hE: h = 4'hF;  default: h = 4'hD;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/key_entry_ctrl_if.sv
// Scanner-side inputs and display-side outputs of key_entry_ctrl.
interface key_entry_ctrl_if;
    logic [7:0] rc;
    logic       en;
    logic [3:0] digit_l;
    logic [3:0] digit_r;
    logic [3:0] hex_out;
    logic [1:0] an;
    logic       new_key;
    logic       err;

    // The controller itself.
    modport slave  (input rc, en, output digit_l, digit_r, hex_out, an, new_key, err);
    // The environment: scanner driving keys, observer of the display.
    modport master (output rc, en, input digit_l, digit_r, hex_out, an, new_key, err);
endinterface

// File: rtl/key_entry_ctrl_keypad_decode.sv
// Combinational keypad decode: row/col one-hot code -> hex nibble + valid.
module keypad_decode
    import key_entry_pkg::*;
(
    input  logic [7:0] rc_i,
    output logic [3:0] hex_o,
    output logic       valid_o
);
    assign valid_o = is_onehot4(rc_i[7:4]) && is_onehot4(rc_i[3:0]);
    assign hex_o   = key_hex(idx4(rc_i[7:4]), idx4(rc_i[3:0]));
endmodule

// File: rtl/key_entry_ctrl.sv
// Two-digit keypad entry register plus a shared seven-segment scheduler
// with anode dead-time. Optional macro ZERO_BLANK_EN: keep the left anode
// off while the left digit is zero (leading-zero suppression).
module key_entry_ctrl
    import key_entry_pkg::*;
#(
    parameter int MUX_DIV      = DEF_MUX_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    key_entry_ctrl_if.slave bus
);
    localparam int CNT_MAX = (MUX_DIV > BLANK_CYCLES) ? MUX_DIV : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [3:0]   key_hex_w;
    logic         key_valid_w;
    logic [3:0]   digit_l_q, digit_l_d, digit_r_q, digit_r_d, hex_q, hex_d;
    logic         new_key_q, new_key_d, err_q, err_d;
    sched_state_t state_q, state_d;
    logic [CW-1:0] count_q, count_d, last_cnt;
    logic [1:0]   an_w;

    keypad_decode u_dec (.rc_i(bus.rc), .hex_o(key_hex_w), .valid_o(key_valid_w));

    // Entry register next-state: shift in a valid key, flag a malformed one.
    always_comb begin
        digit_l_d = digit_l_q;
        digit_r_d = digit_r_q;
        new_key_d = bus.en && key_valid_w;
        err_d     = bus.en && !key_valid_w;
        if (bus.en && key_valid_w) begin
            digit_l_d = digit_r_q;
            digit_r_d = key_hex_w;
        end
    end

    // Scheduler next-state and Moore anode decode.
    always_comb begin
        state_d  = state_q;
        last_cnt = (state_q == SHOW_L || state_q == SHOW_R) ? CW'(MUX_DIV - 1)
                                                            : CW'(BLANK_CYCLES - 1);
        count_d  = count_q + 1'b1;
        if (count_q == last_cnt) begin
            count_d = '0;
            case (state_q)
                SHOW_L:   state_d = BLANK_LR;
                BLANK_LR: state_d = SHOW_R;
                SHOW_R:   state_d = BLANK_RL;
                default:  state_d = SHOW_L;
            endcase
        end
        case (state_q)
`ifdef ZERO_BLANK_EN
            SHOW_L:  an_w = (digit_l_q == 4'd0) ? 2'b11 : 2'b10;
`else
            SHOW_L:  an_w = 2'b10;
`endif
            SHOW_R:  an_w = 2'b01;
            default: an_w = 2'b11;
        endcase
    end

    // Hex feed to the decoder follows the lit digit; held through blanking.
    always_comb begin
        hex_d = hex_q;
        if (state_q == SHOW_L) hex_d = digit_l_q;
        else if (state_q == SHOW_R) hex_d = digit_r_q;
    end

    // All state registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            digit_l_q <= 4'd0;
            digit_r_q <= 4'd0;
            hex_q     <= 4'd0;
            new_key_q <= 1'b0;
            err_q     <= 1'b0;
            state_q   <= BLANK_RL;
            count_q   <= '0;
        end else begin
            digit_l_q <= digit_l_d;
            digit_r_q <= digit_r_d;
            hex_q     <= hex_d;
            new_key_q <= new_key_d;
            err_q     <= err_d;
            state_q   <= state_d;
            count_q   <= count_d;
        end
    end

    assign bus.digit_l = digit_l_q;
    assign bus.digit_r = digit_r_q;
    assign bus.hex_out = hex_q;
    assign bus.an      = an_w;
    assign bus.new_key = new_key_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_key_entry_ctrl.sv
// Bench for key_entry_ctrl (MUX_DIV=8, BLANK_CYCLES=2): directed steps then
// random keys/resets, compared each cycle against a cycle-position model.
module tb_key_entry_ctrl;
    localparam int M = 8;
    localparam int B = 2;
    localparam int PERIOD = 2 * (M + B);

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    key_entry_ctrl_if bus ();

    key_entry_ctrl #(.MUX_DIV(M), .BLANK_CYCLES(B)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int         cyc = 0;       // edges since reset released
    logic [3:0] m_dl = 0, m_dr = 0, m_hx = 0;
    logic       m_nk = 0, m_er = 0;
    logic [3:0] legend [16];

    // 0=left lit, 1=dead LR, 2=right lit, 3=dead RL, from position in period
    function automatic int phase(input int k);
        int p;
        p = k % PERIOD;
        if (p < B) return 3;
        if (p < B + M) return 0;
        if (p < 2 * B + M) return 1;
        return 2;
    endfunction

    function automatic logic [1:0] exp_an();
        int ph;
        ph = phase(cyc);
        if (ph == 2) return 2'b01;
        if (ph == 0) begin
`ifdef ZERO_BLANK_EN
            if (m_dl == 4'd0) return 2'b11;
`endif
            return 2'b10;
        end
        return 2'b11;
    endfunction

    task automatic model_edge();
        int ph;
        if (!reset) begin
            m_dl = 0; m_dr = 0; m_hx = 0; m_nk = 0; m_er = 0; cyc = 0;
        end else begin
            ph = phase(cyc);
            if (ph == 0) m_hx = m_dl;
            else if (ph == 2) m_hx = m_dr;
            m_nk = 0; m_er = 0;
            if (bus.en) begin
                if ($countones(bus.rc[7:4]) == 1 && $countones(bus.rc[3:0]) == 1) begin
                    m_dl = m_dr;
                    m_dr = legend[$clog2(bus.rc[7:4]) * 4 + $clog2(bus.rc[3:0])];
                    m_nk = 1;
                end else m_er = 1;
            end
            cyc++;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("an",      8'(bus.an),      8'(exp_an()));
        check("hex_out", 8'(bus.hex_out), 8'(m_hx));
        check("digit_l", 8'(bus.digit_l), 8'(m_dl));
        check("digit_r", 8'(bus.digit_r), 8'(m_dr));
        check("new_key", 8'(bus.new_key), 8'(m_nk));
        check("err",     8'(bus.err),     8'(m_er));
    endtask

    task automatic press(input logic [7:0] code);
        bus.en = 1'b1;
        bus.rc = code;
        tick();
        bus.en = 1'b0;
        bus.rc = 8'h00;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [3:0] onehot_rand();
        return 4'b0001 << $urandom_range(3, 0);
    endfunction

    initial begin
        logic [15:0][3:0] lg;
        lg = 64'hD_F_0_E_C_9_8_7_B_6_5_4_A_3_2_1;
        for (int i = 0; i < 16; i++) legend[i] = lg[i];
        bus.en = 1'b0;
        bus.rc = 8'h00;

        // 1: reset then two full scheduler periods
        run(5);
        reset = 1'b1;
        run(2 * PERIOD);

        // 2: valid keys "1" then "D"
        press(8'b0001_0001);
        run(2);
        press(8'b1000_1000);
        run(3);

        // 3: malformed codes
        press(8'b0011_0001);
        run(1);
        press(8'b0001_0000);
        run(2);

        // 4: key "8" in the middle of the right digit window
        while (phase(cyc) != 2 || (cyc % PERIOD) != PERIOD - 4) tick();
        press(8'b0100_0010);
        run(4);

        // back-to-back valid keys
        press(8'b0010_0100);
        press(8'b0100_0100);
        run(3);

        // 5: reset mid right window
        while (phase(cyc) != 2) tick();
        run(3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        run(PERIOD + 4);

        // 6: left zero then nonzero (leading-zero suppression when enabled)
        press(8'b0010_0010);   // 5
        run(PERIOD);
        press(8'b0001_0010);   // 2 -> left becomes 5
        run(PERIOD);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99, 0) < 2) reset = 1'b0;
            else reset = 1'b1;
            bus.en = ($urandom_range(99, 0) < 30);
            if ($urandom_range(1, 0) == 1) bus.rc = {onehot_rand(), onehot_rand()};
            else bus.rc = 8'($urandom);
            tick();
        end
        bus.en = 1'b0;
        reset = 1'b1;
        run(PERIOD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_entry_ctrl.md
Name: key_entry_ctrl

Overview:
Sits between the keypad scanner (rc[7:0] and one-cycle en strobe) and the board's single shared seven-segment decoder driving a two-digit common-anode display. Decodes each accepted key to hex and shifts it into a two-digit entry register (newest digit on the right). Schedules the shared decoder between the left and right digits with anode dead-time to prevent ghosting.

Parameters:
MUX_DIV, 24_000, cycles each digit is lit (48 MHz -> ~1 kHz per digit); legal range >= 2
BLANK_CYCLES, 48, dead-time cycles with both anodes off between digits; legal range >= 1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset (reset==0 resets on posedge clk)
rc  input  8  key code from scanner: rc[7:4] one-hot row (rc[4]=row0), rc[3:0] one-hot col (rc[0]=col0)
en  input  1  one-cycle strobe, rc valid
digit_l  output  4  older entered digit
digit_r  output  4  newest entered digit
hex_out  output  4  nibble to the shared seven-segment decoder
an  output  2  anode enables, active-low; an[1]=left, an[0]=right
new_key  output  1  one-cycle pulse: a valid key was accepted
err  output  1  one-cycle pulse: en with non-one-hot row or col

Behaviour:
- Reset values: digit_l=0, digit_r=0, hex_out=0, an=2'b11, new_key=0, err=0; scheduler state BLANK_RL, count=0.
- Keypad map (row0..row3 x col0..col3): 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
- Entry: en=1 at edge t with rc valid (both nibbles exactly one-hot) -> at t+1: digit_l<=digit_r, digit_r<=decoded, new_key=1 for one cycle.
- en=1 with invalid rc (zero or multiple bits in either nibble) -> digits unchanged, err=1 for one cycle.
- en=0 -> rc ignored; new_key=err=0.
- Back-to-back en on consecutive cycles: each is processed; two valid keys shift twice.
- Scheduler FSM, count 0..N-1 then advance and clear count:
  SHOW_L (N=MUX_DIV) -> BLANK_LR (N=BLANK_CYCLES) -> SHOW_R (N=MUX_DIV) -> BLANK_RL (N=BLANK_CYCLES) -> SHOW_L.
  Full period = 2*(MUX_DIV+BLANK_CYCLES) cycles.
- an is a Moore decode of the state register: SHOW_L=2'b10, SHOW_R=2'b01, BLANK_*=2'b11. Both anodes are never active together.
- hex_out is registered: digit_l in SHOW_L, digit_r in SHOW_R. During BLANK_* it holds its last value.
- A digit update and a scheduler transition in the same cycle are independent. While a SHOW state is active, hex_out reflects the updated digit one cycle after the digit register changes, i.e. two cycles after the en edge.
- Count width: $clog2(max(MUX_DIV,BLANK_CYCLES)).
- Reset asserted mid-operation, in any state: all state and outputs return to reset values at the next edge.

Optional Feature:
ZERO_BLANK_EN
- Defined: when digit_l==0, an[1] stays 1 during SHOW_L (leading-zero suppression). Timing and all other outputs are unchanged.
- Undefined: left digit is always lit in SHOW_L.

Decomposition:
- Package key_entry_pkg:
  - sched_state_t enum {SHOW_L, BLANK_LR, SHOW_R, BLANK_RL}
  - default parameter constants
  - keymap constant / function rc->hex
- One combinational sub-module, keypad_decode: rc -> hex[3:0], valid.
- Top holds the entry register, scheduler FSM and counter.

Test Plan (MUX_DIV=8, BLANK_CYCLES=2):
1. Hold reset=0 5 cycles, release -> an=11 for 2 cycles, 10 for 8, 11 for 2, 01 for 8; period 20, repeating; digits and hex_out =0.
2. en pulse with rc=8'b0001_0001, then rc=8'b1000_1000 -> digit_r=1 with new_key pulse; then digit_l=1, digit_r=D, second new_key pulse; err never set.
3. en with rc=8'b0011_0001 and with rc=8'b0001_0000 -> err pulses once each, digits unchanged, new_key=0.
4. en with rc=8'b0100_0010 (row2 col1 -> 8) during mid-SHOW_R -> hex_out=8 two cycles after the en edge; an stays 01.
5. reset=0 asserted mid-SHOW_R after digits loaded -> next edge digits=0, an=11, hex_out=0; scheduler restarts at BLANK_RL timing.
6. ZERO_BLANK_EN defined, digit_l=0, digit_r=5 -> an never 10; after a second key, left digit becomes nonzero -> an=10 in SHOW_L.
